// File: rtl/bowl_scorekeeper.sv
// bowl_scorekeeper: ten-pin frame/ball/rack tracking with strike/spare bonus scoring
// Ports: CLOCK_50 clock, resetn async active-low reset; throw_valid/throw_pins/throw_ready
// throw handshake (one throw per 3 cycles); total_score, frame, ball, pins_up game state;
// strike, spare, rack_reset, round_reset one-cycle pulses; game_over level until reset.
// SCORE_HISTORY_EN adds hist_sel (frame number 1..NUM_FRAMES) and hist_score, the
// cumulative score at the end of that frame including bonuses landed since.
module bowl_scorekeeper #(
  parameter int NUM_FRAMES = 10,
  parameter int PINS = 10,
  parameter int SCORE_W = 9
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               throw_valid,
  input  logic [3:0]         throw_pins,
`ifdef SCORE_HISTORY_EN
  input  logic [3:0]         hist_sel,
  output logic [SCORE_W-1:0] hist_score,
`endif
  output logic               throw_ready,
  output logic [SCORE_W-1:0] total_score,
  output logic [3:0]         frame,
  output logic [1:0]         ball,
  output logic [3:0]         pins_up,
  output logic               strike,
  output logic               spare,
  output logic               rack_reset,
  output logic               round_reset,
  output logic               game_over
);
  typedef enum logic [1:0] {IDLE, CAPTURE, UPDATE, DONE} state_t;
  localparam logic [3:0] P = 4'(PINS);
  localparam logic [3:0] NF = 4'(NUM_FRAMES);
  state_t state;
  logic [3:0] raw_q, p_q;
  // ba: bonus unit carried from the strike two rolls back, bc: from the mark on the
  // previous roll; together they form the current roll's bonus weight. bb is the
  // pending second unit of the latest strike.
  logic tenth_x, ba, bc, bb;
  logic last, fill, clear, is_strike, is_spare, mark, frame_end, game_end, rack;
  logic [1:0] w;
  logic [5:0] prod;
  logic [SCORE_W-1:0] new_total;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input logic [5:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {{(SCORE_W-5){1'b0}}, b};
    return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction

  assign last = frame == NF;
  // tenth_x marks a strike on the first ball of the final frame; both later balls are fills
  assign fill = last && (ball == 2'd2 || (ball == 2'd1 && tenth_x));
  assign clear = p_q == pins_up;
  // clearing a full rack on the second ball of a normal frame (after a 0) is a spare
  assign is_strike = clear && pins_up == P && (ball == 2'd0 || fill);
  assign is_spare = clear && !is_strike;
  assign mark = (is_strike || is_spare) && !fill;
  assign w = {1'b0, !fill} + {1'b0, ba} + {1'b0, bc};
  assign prod = {2'b0, p_q} * {4'b0, w};
  assign new_total = sat_add(total_score, prod);
  assign frame_end = !last && (ball != 2'd0 || is_strike);
  assign game_end = last && (ball == 2'd2 || (ball == 2'd1 && !tenth_x && !clear));
  assign rack = frame_end || (last && clear);

  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      throw_ready <= 1'b1;
      raw_q <= '0;
      p_q <= '0;
      total_score <= '0;
      frame <= 4'd1;
      ball <= '0;
      pins_up <= P;
      {tenth_x, ba, bc, bb} <= '0;
      {strike, spare, rack_reset, round_reset, game_over} <= '0;
    end else begin
      {strike, spare, rack_reset, round_reset} <= '0;
      case (state)
        IDLE: if (throw_valid) begin
          raw_q <= throw_pins;
          throw_ready <= 1'b0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          p_q <= raw_q > pins_up ? pins_up : raw_q;
          state <= UPDATE;
        end
        UPDATE: begin
          total_score <= new_total;
          frame <= frame_end ? frame + 4'd1 : frame;
          ball <= frame_end ? 2'd0 : game_end ? ball : ball + 2'd1;
          pins_up <= rack ? P : pins_up - p_q;
          tenth_x <= tenth_x || (last && ball == 2'd0 && is_strike);
          ba <= bb;
          bc <= mark;
          bb <= is_strike && !fill;
          strike <= is_strike;
          spare <= is_spare;
          rack_reset <= rack;
          round_reset <= frame_end;
          game_over <= game_end;
          throw_ready <= !game_end;
          state <= game_end ? DONE : IDLE;
        end
        default: ;
      endcase
    end

`ifdef SCORE_HISTORY_EN
  logic [SCORE_W-1:0] hist [NUM_FRAMES];
  // frame that owns each pending bonus unit; a landing unit raises every recorded
  // frame from its owner onward
  logic [3:0] oa, oc, ob;

  function automatic logic [5:0] late_bonus(input logic [3:0] f);
    return {2'b0, p_q} * ({5'b0, ba && f >= oa} + {5'b0, bc && f >= oc});
  endfunction

  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      for (int i = 0; i < NUM_FRAMES; i++) hist[i] <= '0;
      {oa, oc, ob} <= '0;
    end else if (state == UPDATE) begin
      {oa, oc, ob} <= {ob, frame, frame};
      for (int i = 0; i < NUM_FRAMES; i++)
        if (4'(i + 1) == frame && (frame_end || game_end)) hist[i] <= new_total;
        else if (4'(i + 1) < frame) hist[i] <= sat_add(hist[i], late_bonus(4'(i + 1)));
    end

  assign hist_score = (hist_sel != 4'd0 && hist_sel <= NF) ? hist[hist_sel - 4'd1] : '0;
`endif
endmodule
